mode7_coord_gen: RTL and testbench

//  Mode-7 affine scanline walker feeding the 8x8-tile texture lookup stage.
//  Per scanline: latch start (u,v) and per-pixel step (du,dv); per pixel: step fixed-point accumulators.

---
 rtl/mode7_coord_gen_if.sv | 29 ++
 rtl/mode7_coord_gen.sv | 140 ++++++++++++++
 tb/tb_mode7_coord_gen.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mode7_coord_gen_if.sv
// mode7_coord_gen_if: scanline control, tile-map port and texel output bundle for the Mode-7 walker
interface mode7_coord_gen_if #(
    parameter int COORD_W = 18,
    parameter int MAP_W   = 5
);
    logic               line_start_i;
    logic [COORD_W-1:0] u0_i;
    logic [COORD_W-1:0] v0_i;
    logic [COORD_W-1:0] du_i;
    logic [COORD_W-1:0] dv_i;
    logic               pix_en_i;
    logic               line_busy_o;
    logic [2*MAP_W-1:0] map_addr_o;
    logic [5:0]         map_data_i;
    logic [5:0]         texture_idx_o;
    logic [2:0]         y_idx_o;
    logic [2:0]         x_idx_o;
    logic               out_valid_o;

    modport slave (
        input  line_start_i, u0_i, v0_i, du_i, dv_i, pix_en_i, map_data_i,
        output line_busy_o, map_addr_o, texture_idx_o, y_idx_o, x_idx_o, out_valid_o
    );

    modport master (
        output line_start_i, u0_i, v0_i, du_i, dv_i, pix_en_i, map_data_i,
        input  line_busy_o, map_addr_o, texture_idx_o, y_idx_o, x_idx_o, out_valid_o
    );
endinterface

// File: rtl/mode7_coord_gen.sv
// mode7_coord_gen: affine u/v scanline walker with tile-map lookup; MODE7_BORDER_EN selects border tile for out-of-map texels
module mode7_coord_gen #(
    parameter int COORD_W     = 18,
    parameter int FRAC_BITS   = 8,
    parameter int MAP_W       = 5,
    parameter int LINE_PIXELS = 640
) (
    input logic clk,
    input logic reset,
    mode7_coord_gen_if.slave bus
);
    localparam int CNT_W   = $clog2(LINE_PIXELS);
    localparam int OOB_LSB = FRAC_BITS + 3 + MAP_W;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] u_q, u_d, v_q, v_d, du_q, du_d, dv_q, dv_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept, last;
    logic [2*MAP_W-1:0] map_addr_q;
    logic [2:0]         x1_q, y1_q, x2_q, y2_q, x_out_q, y_out_q;
    logic               val1_q, val2_q, out_valid_q;
    logic [5:0]         tex_d, tex_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: a new line (or restart) beats finishing the current one
    always_comb begin
        state_d = state_q;
        if (bus.line_start_i)  state_d = RUN;
        else if (accept && last) state_d = IDLE;
    end

    // FSM outputs: busy flag and pixel acceptance (line_start suppresses the pixel)
    always_comb begin
        bus.line_busy_o = state_q == RUN;
        accept          = state_q == RUN && bus.pix_en_i && !bus.line_start_i;
        last            = cnt_q == CNT_W'(LINE_PIXELS - 1);
    end

    // Accumulator next state: latch line parameters or step by one pixel, wrapping
    always_comb begin
        u_d   = u_q;
        v_d   = v_q;
        du_d  = du_q;
        dv_d  = dv_q;
        cnt_d = cnt_q;
        if (bus.line_start_i) begin
            u_d   = bus.u0_i;
            v_d   = bus.v0_i;
            du_d  = bus.du_i;
            dv_d  = bus.dv_i;
            cnt_d = '0;
        end else if (accept) begin
            u_d   = u_q + du_q;
            v_d   = v_q + dv_q;
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Accumulator registers
    always_ff @(posedge clk) begin
        if (reset) begin
            u_q   <= '0;
            v_q   <= '0;
            du_q  <= '0;
            dv_q  <= '0;
            cnt_q <= '0;
        end else begin
            u_q   <= u_d;
            v_q   <= v_d;
            du_q  <= du_d;
            dv_q  <= dv_d;
            cnt_q <= cnt_d;
        end
    end

    // Pipeline: address/texel split, wait for the RAM read, then register the pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            map_addr_q  <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            val1_q      <= 1'b0;
            x2_q        <= '0;
            y2_q        <= '0;
            val2_q      <= 1'b0;
            tex_q       <= '0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                map_addr_q <= {v_q[OOB_LSB-1:FRAC_BITS+3], u_q[OOB_LSB-1:FRAC_BITS+3]};
                x1_q       <= u_q[FRAC_BITS+2:FRAC_BITS];
                y1_q       <= v_q[FRAC_BITS+2:FRAC_BITS];
            end
            val1_q <= accept;
            x2_q   <= x1_q;
            y2_q   <= y1_q;
            val2_q <= val1_q;
            if (val2_q) begin
                tex_q   <= tex_d;
                x_out_q <= x2_q;
                y_out_q <= y2_q;
            end
            out_valid_q <= val2_q;
        end
    end

`ifdef MODE7_BORDER_EN
    logic oob1_q, oob2_q;

    // Out-of-map flag travels alongside the map lookup
    always_ff @(posedge clk) begin
        if (reset) begin
            oob1_q <= 1'b0;
            oob2_q <= 1'b0;
        end else begin
            if (accept) oob1_q <= (|(u_q >> OOB_LSB)) || (|(v_q >> OOB_LSB));
            oob2_q <= oob1_q;
        end
    end

    assign tex_d = oob2_q ? 6'h00 : bus.map_data_i;
`else
    assign tex_d = bus.map_data_i;
`endif

    assign bus.map_addr_o    = map_addr_q;
    assign bus.texture_idx_o = tex_q;
    assign bus.x_idx_o       = x_out_q;
    assign bus.y_idx_o       = y_out_q;
    assign bus.out_valid_o   = out_valid_q;
endmodule

// File: tb/tb_mode7_coord_gen.sv
// tb_mode7_coord_gen: directed checks of the Mode-7 coordinate walker
module tb_mode7_coord_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   nvalid = 0;
    int   base = 0;
    bit   ram_mode = 1'b0;
    logic [2:0] xlog [0:1023];
    logic [2:0] ylog [0:1023];
    logic [5:0] tlog [0:1023];

    mode7_coord_gen_if bus ();

    mode7_coord_gen dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Tile-map RAM: constant tile, or tile number = low address bits {row[0], col}
    always @(posedge clk) bus.map_data_i <= ram_mode ? bus.map_addr_o[5:0] : 6'h2A;

    // Output logger
    always @(negedge clk) begin
        if (bus.out_valid_o === 1'b1) begin
            if (nvalid - base >= 0 && nvalid - base < 1024) begin
                xlog[nvalid-base] <= bus.x_idx_o;
                ylog[nvalid-base] <= bus.y_idx_o;
                tlog[nvalid-base] <= bus.texture_idx_o;
            end
            nvalid <= nvalid + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_line(input logic [17:0] u0, input logic [17:0] v0,
                              input logic [17:0] du, input logic [17:0] dv);
        bus.u0_i = u0;
        bus.v0_i = v0;
        bus.du_i = du;
        bus.dv_i = dv;
        bus.line_start_i = 1'b1;
        @(negedge clk);
        bus.line_start_i = 1'b0;
    endtask

    task automatic finish_line(input string tag);
        for (int i = 0; i < 2000 && bus.line_busy_o === 1'b1; i++) @(negedge clk);
        check(tag, 32'(bus.line_busy_o), 32'd0);
        bus.pix_en_i = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        bus.line_start_i = 1'b0;
        bus.u0_i = '0;
        bus.v0_i = '0;
        bus.du_i = '0;
        bus.dv_i = '0;
        bus.pix_en_i = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        // reset state
        check("rst_valid", 32'(bus.out_valid_o), 32'd0);
        check("rst_busy", 32'(bus.line_busy_o), 32'd0);
        check("rst_addr", 32'(bus.map_addr_o), 32'd0);
        check("rst_tex", 32'(bus.texture_idx_o), 32'd0);
        check("rst_x", 32'(bus.x_idx_o), 32'd0);
        check("rst_y", 32'(bus.y_idx_o), 32'd0);

        // pix_en without line_start is ignored
        base = nvalid;
        bus.pix_en_i = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_valid", 32'(bus.out_valid_o), 32'd0);
        check("idle_busy", 32'(bus.line_busy_o), 32'd0);
        check("idle_addr", 32'(bus.map_addr_o), 32'd0);
        check("idle_count", 32'(nvalid - base), 32'd0);
        bus.pix_en_i = 1'b0;
        @(negedge clk);

        // unit step in u, constant tile 0x2A, latency 2
        base = nvalid;
        start_line(18'h0, 18'h0, 18'h100, 18'h0);
        check("t2_busy", 32'(bus.line_busy_o), 32'd1);
        bus.pix_en_i = 1'b1;
        @(negedge clk);
        check("t2_lat_e0", 32'(bus.out_valid_o), 32'd0);
        check("t2_addr0", 32'(bus.map_addr_o), 32'd0);
        @(negedge clk);
        check("t2_lat_e1", 32'(bus.out_valid_o), 32'd0);
        @(negedge clk);
        check("t2_lat_e2", 32'(bus.out_valid_o), 32'd1);
        check("t2_x0", 32'(bus.x_idx_o), 32'd0);
        check("t2_tex0", 32'(bus.texture_idx_o), 32'h2A);
        finish_line("t2_end");
        check("t2_count", 32'(nvalid - base), 32'd640);
        check("t2_x7", 32'(xlog[7]), 32'd7);
        check("t2_x8", 32'(xlog[8]), 32'd0);
        check("t2_x639", 32'(xlog[639]), 32'd7);
        check("t2_tex639", 32'(tlog[639]), 32'h2A);
        check("t2_addr_hold", 32'(bus.map_addr_o), 32'd15);
        check("t2_valid_off", 32'(bus.out_valid_o), 32'd0);

        // half-texel u step, quarter-texel v step, address-derived tiles
        ram_mode = 1'b1;
        base = nvalid;
        start_line(18'h0, 18'h0, 18'h080, 18'h040);
        bus.pix_en_i = 1'b1;
        finish_line("t3_end");
        check("t3_count", 32'(nvalid - base), 32'd640);
        check("t3_x2", 32'(xlog[2]), 32'd1);
        check("t3_x3", 32'(xlog[3]), 32'd1);
        check("t3_x4", 32'(xlog[4]), 32'd2);
        check("t3_y5", 32'(ylog[5]), 32'd1);
        check("t3_x31", 32'(xlog[31]), 32'd7);
        check("t3_y31", 32'(ylog[31]), 32'd7);
        check("t3_tex16", 32'(tlog[16]), 32'h01);
        check("t3_tex31", 32'(tlog[31]), 32'h01);
        check("t3_tex33", 32'(tlog[33]), 32'h22);

        // map edge: tile_col 31 -> next pixel wraps or hits border
        base = nvalid;
        start_line(18'h0FF00, 18'h00800, 18'h100, 18'h0);
        bus.pix_en_i = 1'b1;
        finish_line("t4_end");
        check("t4_x0", 32'(xlog[0]), 32'd7);
        check("t4_y0", 32'(ylog[0]), 32'd0);
        check("t4_tex0", 32'(tlog[0]), 32'h3F);
        check("t4_x1", 32'(xlog[1]), 32'd0);
        check("t4_x2", 32'(xlog[2]), 32'd1);
`ifdef MODE7_BORDER_EN
        check("t4_tex1", 32'(tlog[1]), 32'h00);
        check("t4_tex2", 32'(tlog[2]), 32'h00);
`else
        check("t4_tex1", 32'(tlog[1]), 32'h20);
        check("t4_tex2", 32'(tlog[2]), 32'h20);
`endif

        // restart: line_start sampled on the edge that would accept pixel 102
        base = nvalid;
        start_line(18'h0, 18'h0, 18'h100, 18'h0);
        bus.pix_en_i = 1'b1;
        repeat (102) @(negedge clk);
        bus.u0_i = 18'h300;
        bus.line_start_i = 1'b1;
        @(negedge clk);
        bus.line_start_i = 1'b0;
        finish_line("t5_end");
        check("t5_count", 32'(nvalid - base), 32'd742);
        check("t5_x101", 32'(xlog[101]), 32'd5);
        check("t5_x102", 32'(xlog[102]), 32'd3);
        check("t5_x103", 32'(xlog[103]), 32'd4);
        check("t5_x741", 32'(xlog[741]), 32'd2);

        // reset in mid-line flushes the pipeline
        base = nvalid;
        start_line(18'h0, 18'h0, 18'h100, 18'h0);
        bus.pix_en_i = 1'b1;
        repeat (50) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_valid", 32'(bus.out_valid_o), 32'd0);
        check("t6_busy", 32'(bus.line_busy_o), 32'd0);
        check("t6_addr", 32'(bus.map_addr_o), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_busy_after", 32'(bus.line_busy_o), 32'd0);
        check("t6_valid_after", 32'(bus.out_valid_o), 32'd0);
        check("t6_count", 32'(nvalid - base), 32'd48);
        bus.pix_en_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
